// File: rtl/fir_pkg.sv
// Shared types and constants for the two-channel FIR MAC scheduler.
package fir_pkg;

  localparam int unsigned TAPS_DEFAULT = 16;
  localparam int unsigned NUM_CH       = 2;

  typedef enum logic [1:0] {
    waiting,
    loading,
    processing,
    saving
  } state_type;

  typedef logic signed [15:0] sample_t;
  typedef logic signed [31:0] acc_t;

endpackage

// File: rtl/fir_addr_counter.sv
// Sample/coefficient address counter for the MAC loop: clear has priority
// over enable, and tc flags the last tap so the scheduler can leave PROCESSING.
module fir_addr_counter
  import fir_pkg::*;
#(
  parameter  int unsigned TAPS = TAPS_DEFAULT,
  localparam int unsigned AW   = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  output logic [AW-1:0] count,
  output logic          tc
);

  logic [AW-1:0] count_q;
  logic [AW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + AW'(1);
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == AW'(TAPS - 1));

endmodule

// File: rtl/fir_channel_scheduler.sv
// Two-channel round-robin scheduler sharing one FIR MAC datapath:
// WAITING -> LOADING -> PROCESSING (TAPS cycles) -> SAVING per sample.
module fir_channel_scheduler
  import fir_pkg::*;
#(
  parameter  int unsigned TAPS = TAPS_DEFAULT,
  localparam int unsigned AW   = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic          ck,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic          clr_overrun,
  output logic          load,
  output logic          ch_sel,
  output logic [AW-1:0] address,
  output logic          reset_accumulator,
  output logic          output_ready,
  output logic          out_ch,
  output logic [1:0]    overrun,
  output logic          busy
);

  state_type  state_q, state_d;
  logic [1:0] pend_q, pend_d;
  logic [1:0] overrun_q, overrun_d;
  logic       last_grant_q, last_grant_d;
  logic       ch_sel_q, ch_sel_d;

  logic       grant_ch;
  logic [1:0] pend_clr;
  logic       cnt_clear;
  logic       cnt_en;
  logic       addr_tc;

  fir_addr_counter #(
    .TAPS (TAPS)
  ) u_addr_counter (
    .ck     (ck),
    .rst    (rst),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .count  (address),
    .tc     (addr_tc)
  );

  // Round-robin pick: contention goes to the channel not served last.
  always_comb begin
    grant_ch = 1'b0;
    if (pend_q == 2'b11) begin
      grant_ch = ~last_grant_q;
    end else begin
      grant_ch = pend_q[1];
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ch_sel_d     = ch_sel_q;
    pend_clr     = 2'b00;
    cnt_clear    = 1'b1;
    cnt_en       = 1'b0;
    case (state_q)
      waiting: begin
        if (pend_q != 2'b00) begin
          pend_clr[grant_ch] = 1'b1;
          ch_sel_d           = grant_ch;
          last_grant_d       = grant_ch;
          state_d            = loading;
        end
      end
      loading: begin
        state_d = processing;
      end
      processing: begin
        cnt_en    = 1'b1;
        cnt_clear = addr_tc;
        if (addr_tc) begin
          state_d = saving;
        end
      end
      saving: begin
        state_d = waiting;
      end
      default: begin
        state_d = waiting;
      end
    endcase
  end

  // A new request beats the grant's clear; a request onto a still-pending
  // channel is a lost sample, and that set beats clr_overrun.
  always_comb begin
    pend_d    = req | (pend_q & ~pend_clr);
    overrun_d = (req & pend_q & ~pend_clr) | (overrun_q & {2{~clr_overrun}});
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q      <= waiting;
      pend_q       <= 2'b00;
      overrun_q    <= 2'b00;
      last_grant_q <= 1'b1;
      ch_sel_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      overrun_q    <= overrun_d;
      last_grant_q <= last_grant_d;
      ch_sel_q     <= ch_sel_d;
    end
  end

  assign load              = (state_q == loading);
  assign reset_accumulator = (state_q == waiting) || (state_q == loading);
  assign output_ready      = (state_q == saving);
  assign out_ch            = (state_q == saving) && ch_sel_q;
  assign busy              = (state_q != waiting);
  assign ch_sel            = ch_sel_q;
  assign overrun           = overrun_q;

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Directed bench for fir_channel_scheduler: per-cycle checks of all outputs
// against hand-planned service timelines (LOADING cycle and channel per sample).
module tb_fir_channel_scheduler;

  localparam int unsigned TAPS = 16;
  localparam int unsigned AW   = 4;
  localparam logic [15:0] RESET_WORD = 16'h0200;

  logic          ck = 1'b0;
  logic          rst;
  logic [1:0]    req;
  logic          clr_overrun;
  logic          load;
  logic          ch_sel;
  logic [AW-1:0] address;
  logic          reset_accumulator;
  logic          output_ready;
  logic          out_ch;
  logic [1:0]    overrun;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  int svc_l[$];
  int svc_ch[$];
  int rq_c[$];
  logic [1:0] rq_v[$];
  int clr_c[$];
  int ovr_lo;
  int ovr_hi;

  fir_channel_scheduler #(
    .TAPS (TAPS)
  ) dut (
    .ck                (ck),
    .rst               (rst),
    .req               (req),
    .clr_overrun       (clr_overrun),
    .load              (load),
    .ch_sel            (ch_sel),
    .address           (address),
    .reset_accumulator (reset_accumulator),
    .output_ready      (output_ready),
    .out_ch            (out_ch),
    .overrun           (overrun),
    .busy              (busy)
  );

  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] obs_word();
    return {4'b0, busy, load, reset_accumulator, output_ready, out_ch, ch_sel, overrun, address};
  endfunction

  // Expected outputs in cycle c given the planned services.
  function automatic logic [15:0] exp_word(input int c, input logic prev_ch, input logic [1:0] ovr);
    logic busy_e, load_e, racc_e, ordy_e, och_e, chs_e;
    logic [3:0] a_e;
    busy_e = 1'b0; load_e = 1'b0; racc_e = 1'b1; ordy_e = 1'b0;
    och_e = 1'b0; chs_e = prev_ch; a_e = 4'd0;
    foreach (svc_l[i]) begin
      if (c >= svc_l[i]) chs_e = (svc_ch[i] != 0);
      if (c == svc_l[i]) begin
        busy_e = 1'b1; load_e = 1'b1;
      end else if (c > svc_l[i] && c <= svc_l[i] + int'(TAPS)) begin
        busy_e = 1'b1; racc_e = 1'b0; a_e = 4'(c - svc_l[i] - 1);
      end else if (c == svc_l[i] + int'(TAPS) + 1) begin
        busy_e = 1'b1; racc_e = 1'b0; ordy_e = 1'b1; och_e = chs_e;
      end
    end
    return {4'b0, busy_e, load_e, racc_e, ordy_e, och_e, chs_e, ovr, a_e};
  endfunction

  task automatic clear_plan();
    svc_l.delete(); svc_ch.delete(); rq_c.delete(); rq_v.delete(); clr_c.delete();
    ovr_lo = -1; ovr_hi = -2;
  endtask

  task automatic add_svc(input int l, input int ch);
    svc_l.push_back(l); svc_ch.push_back(ch);
  endtask

  task automatic add_req(input int c, input logic [1:0] v);
    rq_c.push_back(c); rq_v.push_back(v);
  endtask

  // Entered just after a rising edge; that cycle is c=0.
  task automatic run_scn(input string name, input int ncyc, input logic prev_ch);
    for (int c = 0; c < ncyc; c++) begin
      req = 2'b00;
      clr_overrun = 1'b0;
      foreach (rq_c[i]) if (rq_c[i] == c) req = req | rq_v[i];
      foreach (clr_c[i]) if (clr_c[i] == c) clr_overrun = 1'b1;
      @(negedge ck);
      check($sformatf("%s_c%0d", name, c), obs_word(),
            exp_word(c, prev_ch, (c >= ovr_lo && c <= ovr_hi) ? 2'b01 : 2'b00));
      @(posedge ck);
      #1;
    end
    req = 2'b00;
    clr_overrun = 1'b0;
  endtask

  task automatic reset_dut(input string name);
    rst = 1'b1;
    req = 2'b00;
    clr_overrun = 1'b0;
    repeat (2) @(posedge ck);
    @(negedge ck);
    check(name, obs_word(), RESET_WORD);
    @(posedge ck);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req = 2'b00;
    clr_overrun = 1'b0;

    reset_dut("rst0");

    // Single request on channel 0: load c2, address 0..15 in c3..18, ready c19.
    clear_plan();
    add_req(0, 2'b01);
    add_svc(2, 0);
    run_scn("single", 22, 1'b0);

    reset_dut("rst1");

    // Simultaneous requests after reset: channel 0 first, channel 1 loads c21.
    clear_plan();
    add_req(0, 2'b11);
    add_svc(2, 0);
    add_svc(21, 1);
    run_scn("both", 41, 1'b0);

    // Both channels every 38 cycles for 10 periods: strict alternation, no overrun.
    clear_plan();
    for (int p = 0; p < 10; p++) begin
      add_req(38 * p, 2'b11);
      add_svc(38 * p + 2, 0);
      add_svc(38 * p + 21, 1);
    end
    run_scn("rr", 38 * 10 + 3, 1'b1);

    reset_dut("rst2");

    // c1 request collides with the grant (pend kept, second service, no overrun);
    // c2 request hits a pending flag (overrun from c3); c5 set beats clear;
    // clr_overrun at c30 clears it from c31.
    clear_plan();
    add_req(0, 2'b01);
    add_req(1, 2'b01);
    add_req(2, 2'b01);
    add_req(5, 2'b01);
    clr_c.push_back(5);
    clr_c.push_back(30);
    ovr_lo = 3;
    ovr_hi = 30;
    add_svc(2, 0);
    add_svc(21, 0);
    run_scn("ovr", 41, 1'b0);

    reset_dut("rst3");

    // Reset at address 7 aborts the operation; the next request sees full latency.
    clear_plan();
    add_req(0, 2'b01);
    add_svc(2, 0);
    run_scn("abort", 10, 1'b0);
    check("abort_addr7", {12'b0, address}, 16'd7);
    rst = 1'b1;
    #1;
    check("abort_rst_now", obs_word(), RESET_WORD);
    @(negedge ck);
    check("abort_rst_hold", obs_word(), RESET_WORD);
    @(posedge ck);
    #1;
    rst = 1'b0;
    clear_plan();
    add_req(0, 2'b01);
    add_svc(2, 0);
    run_scn("after", 22, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
